// File: rtl/shooting_game_pkg.sv
// Shared types and constants for the 8x8 RGB LED-matrix scan interface.
//   NUM_COLS / NUM_ROWS : matrix geometry
//   COL_EN_BIT          : bit of the column bus that enables the column drive
//   rgb_col_t           : one column of the matrix, {r, g, b}, active-high (1 = lit)
//   LED_OFF             : idle value of an active-low row bus
//   to_lit()            : converts the three active-low row buses into an rgb_col_t
package shooting_game_pkg;

  localparam int NUM_COLS   = 8;
  localparam int NUM_ROWS   = 8;
  localparam int COL_EN_BIT = 3;

  typedef struct packed {
    logic [NUM_ROWS-1:0] r;
    logic [NUM_ROWS-1:0] g;
    logic [NUM_ROWS-1:0] b;
  } rgb_col_t;

  localparam logic [NUM_ROWS-1:0] LED_OFF = 8'hFF;

  function automatic rgb_col_t to_lit(input logic [NUM_ROWS-1:0] r_n,
                                      input logic [NUM_ROWS-1:0] g_n,
                                      input logic [NUM_ROWS-1:0] b_n);
    rgb_col_t c;
    c.r = ~r_n;
    c.g = ~g_n;
    c.b = ~b_n;
    return c;
  endfunction

endpackage

// File: rtl/scan_frame_bank.sv
// One frame buffer: NUM_COLS columns of rgb_col_t.
//   CLK, Clear_n : clock, asynchronous active-low reset (contents -> 0)
//   clr          : synchronous clear of the whole bank
//   wr_en        : OR-merge wr_data into column wr_col
//   wr_col       : column written
//   wr_data      : lit bits to merge
//   rd_col       : column read
//   rd_data      : registered read data, 1-cycle latency
// When clr and wr_en coincide the clear takes effect first, so the written
// column ends up holding exactly wr_data and every other column is 0.
module scan_frame_bank
  import shooting_game_pkg::*;
(
  input  logic       CLK,
  input  logic       Clear_n,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [2:0] wr_col,
  input  rgb_col_t   wr_data,
  input  logic [2:0] rd_col,
  output rgb_col_t   rd_data
);

  rgb_col_t mem [NUM_COLS];

  always_ff @(posedge CLK or negedge Clear_n) begin
    if (!Clear_n) begin
      for (int c = 0; c < NUM_COLS; c++) mem[c] <= '0;
      rd_data <= '0;
    end else begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (wr_en && (wr_col == 3'(c))) begin
          mem[c] <= clr ? wr_data : (mem[c] | wr_data);
        end else if (clr) begin
          mem[c] <= '0;
        end
      end
      rd_data <= mem[rd_col];
    end
  end

endmodule

// File: rtl/led_scan_capture.sv
// Receiving end of the 8x8 RGB LED-matrix scan interface. Samples one scan
// slot per scan_tick, rebuilds the frame in a write bank and hands completed
// frames to a read bank (ping-pong) with a valid/ack handshake.
//   CLK, Clear_n        : clock, asynchronous active-low reset
//   scan_tick           : sample the scan buses this cycle
//   scan_sync           : frame-start marker (qualified by scan_tick)
//   column              : [3] column enable, [2:0] column index
//   R/G/B_color         : active-low row buses
//   frame_valid         : read bank holds a complete frame
//   frame_ack           : consumer releases the read bank
//   rd_col, rd_r/g/b    : column read port, active-high, 1-cycle latency
//   overrun_cnt         : saturating count of dropped frames
//   sync_err_cnt        : saturating count of partial frames discarded by sync
module led_scan_capture
  import shooting_game_pkg::*;
#(
  parameter int SLOTS_PER_FRAME = 8,
  parameter int OVR_W           = 8
) (
  input  logic             CLK,
  input  logic             Clear_n,
  input  logic             scan_tick,
  input  logic             scan_sync,
  input  logic [3:0]       column,
  input  logic [7:0]       R_color,
  input  logic [7:0]       G_color,
  input  logic [7:0]       B_color,
  output logic             frame_valid,
  input  logic             frame_ack,
  input  logic [2:0]       rd_col,
  output logic [7:0]       rd_r,
  output logic [7:0]       rd_g,
  output logic [7:0]       rd_b,
  output logic [OVR_W-1:0] overrun_cnt,
  output logic [OVR_W-1:0] sync_err_cnt
);

  localparam int              SLOT_W    = 4;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS_PER_FRAME - 1);

  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    return (&v) ? v : v + OVR_W'(1);
  endfunction

  logic [SLOT_W-1:0] slot_cnt;
  logic              done_p1;    // last slot was merged on the previous cycle
  logic              wr_bank;
  logic              rd_sel_p1;  // read bank index aligned with the registered read data

  logic              sync_hit;
  logic [SLOT_W-1:0] cur_slot;
  logic              last_hit;
  logic              accept;
  logic              tgt_bank;
  logic              clr_any;
  logic              wr_en;
  rgb_col_t          wr_data;
  logic              bank_clr [2];
  logic              bank_we  [2];
  rgb_col_t          bank_rd  [2];
  rgb_col_t          rd_sel;

  // Sample decode and target-bank selection. In the completion cycle a
  // concurrent sample must land in the bank that will be written next, which
  // is also the bank being cleared, so clear and merge share one target.
  always_comb begin
    sync_hit = scan_tick && scan_sync;
    cur_slot = sync_hit ? '0 : slot_cnt;
    last_hit = scan_tick && (cur_slot == LAST_SLOT);
    accept   = done_p1 && (!frame_valid || frame_ack);
    tgt_bank = accept ? ~wr_bank : wr_bank;
    clr_any  = done_p1 || sync_hit;
    wr_en    = scan_tick && column[COL_EN_BIT];
    wr_data  = to_lit(R_color, G_color, B_color);
    for (int i = 0; i < 2; i++) begin
      bank_clr[i] = clr_any && (tgt_bank == 1'(i));
      bank_we[i]  = wr_en   && (tgt_bank == 1'(i));
    end
  end

  scan_frame_bank u_bank0 (
    .CLK     (CLK),
    .Clear_n (Clear_n),
    .clr     (bank_clr[0]),
    .wr_en   (bank_we[0]),
    .wr_col  (column[2:0]),
    .wr_data (wr_data),
    .rd_col  (rd_col),
    .rd_data (bank_rd[0])
  );

  scan_frame_bank u_bank1 (
    .CLK     (CLK),
    .Clear_n (Clear_n),
    .clr     (bank_clr[1]),
    .wr_en   (bank_we[1]),
    .wr_col  (column[2:0]),
    .wr_data (wr_data),
    .rd_col  (rd_col),
    .rd_data (bank_rd[1])
  );

  // Slot counting, completion, handshake and error counters
  always_ff @(posedge CLK or negedge Clear_n) begin
    if (!Clear_n) begin
      slot_cnt     <= '0;
      done_p1      <= 1'b0;
      wr_bank      <= 1'b0;
      rd_sel_p1    <= 1'b1;
      frame_valid  <= 1'b0;
      overrun_cnt  <= '0;
      sync_err_cnt <= '0;
    end else begin
      done_p1   <= last_hit;
      rd_sel_p1 <= ~wr_bank;

      if (scan_tick) begin
        slot_cnt <= last_hit ? '0 : cur_slot + SLOT_W'(1);
        if (sync_hit && (slot_cnt != '0)) sync_err_cnt <= sat_inc(sync_err_cnt);
      end

      if (done_p1) begin
        if (accept) begin
          wr_bank     <= ~wr_bank;
          frame_valid <= 1'b1;
        end else begin
          overrun_cnt <= sat_inc(overrun_cnt);
        end
      end else if (frame_valid && frame_ack) begin
        frame_valid <= 1'b0;
      end
    end
  end

  // Read port: the selected bank already registered its column
  always_comb begin
    rd_sel = rd_sel_p1 ? bank_rd[1] : bank_rd[0];
    rd_r   = rd_sel.r;
    rd_g   = rd_sel.g;
    rd_b   = rd_sel.b;
  end

endmodule

// File: tb/tb_led_scan_capture.sv
module tb_led_scan_capture;
  import shooting_game_pkg::*;

  localparam int OVR_W = 8;

  logic             clk = 1'b0;
  logic             Clear_n;
  logic             scan_tick, scan_sync, frame_ack;
  logic [3:0]       column;
  logic [7:0]       R_color, G_color, B_color;
  logic             frame_valid;
  logic [2:0]       rd_col;
  logic [7:0]       rd_r, rd_g, rd_b;
  logic [OVR_W-1:0] overrun_cnt, sync_err_cnt;

  led_scan_capture #(.SLOTS_PER_FRAME(8), .OVR_W(OVR_W)) dut (
    .CLK          (clk),
    .Clear_n      (Clear_n),
    .scan_tick    (scan_tick),
    .scan_sync    (scan_sync),
    .column       (column),
    .R_color      (R_color),
    .G_color      (G_color),
    .B_color      (B_color),
    .frame_valid  (frame_valid),
    .frame_ack    (frame_ack),
    .rd_col       (rd_col),
    .rd_r         (rd_r),
    .rd_g         (rd_g),
    .rd_b         (rd_b),
    .overrun_cnt  (overrun_cnt),
    .sync_err_cnt (sync_err_cnt)
  );

  always #5 clk = ~clk;

  // kind: 0 = rd_r/g/b, 1 = frame_valid, 2 = overrun_cnt, 3 = sync_err_cnt
  typedef struct {
    int          kind;
    logic [23:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic probe  = 1'b0;

  // Monitor: a probe issued in cycle n is observed after the next edge
  always begin
    exp_t        e;
    logic [23:0] act;
    @(posedge clk);
    if (probe) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL monitor: output with empty scoreboard");
      end else begin
        e = sb.pop_front();
        case (e.kind)
          0:       act = {rd_r, rd_g, rd_b};
          1:       act = {23'b0, frame_valid};
          2:       act = {16'b0, overrun_cnt};
          default: act = {16'b0, sync_err_cnt};
        endcase
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %06h expected %06h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic tick(input logic [3:0] col, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, input logic sync);
    column = col; R_color = r; G_color = g; B_color = b;
    scan_tick = 1'b1; scan_sync = sync;
    step();
    scan_tick = 1'b0; scan_sync = 1'b0; column = 4'b0000;
    R_color = LED_OFF; G_color = LED_OFF; B_color = LED_OFF;
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
  endtask

  task automatic chk(input int kind, input logic [2:0] col, input logic [23:0] exp,
                     input string name);
    exp_t e;
    e.kind = kind; e.exp = exp; e.name = name;
    sb.push_back(e);
    rd_col = col;
    probe  = 1'b1;
    step();
    probe  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bit_k;
    Clear_n = 1'b0; scan_tick = 1'b0; scan_sync = 1'b0; frame_ack = 1'b0;
    column = 4'b0000; R_color = LED_OFF; G_color = LED_OFF; B_color = LED_OFF;
    rd_col = 3'd0;
    idle(3);
    Clear_n = 1'b1;
    idle(1);

    // Reset state
    chk(1, 0, 24'h0, "rst_valid");
    chk(2, 0, 24'h0, "rst_overrun");
    chk(3, 0, 24'h0, "rst_syncerr");
    chk(0, 3, 24'h0, "rst_rd");

    // Basic frame: red diagonal
    for (int k = 0; k < 8; k++) begin
      bit_k = 8'h01 << k;
      tick(4'b1000 | 4'(k), ~bit_k, LED_OFF, LED_OFF, 1'b0);
    end
    idle(2);
    chk(1, 0, 24'h1, "frame_valid");
    for (int k = 0; k < 8; k++) begin
      bit_k = 8'h01 << k;
      chk(0, 3'(k), {bit_k, 8'h00, 8'h00}, $sformatf("frame_col%0d", k));
    end

    // Ack then merge/blank frame
    ack();
    chk(1, 0, 24'h0, "ack_drops_valid");
    tick(4'b1010, 8'hFE, LED_OFF, LED_OFF, 1'b0);
    tick(4'b0100, 8'h00, 8'h00, 8'h00, 1'b0);
    tick(4'b0100, 8'h00, 8'h00, 8'h00, 1'b0);
    tick(4'b1010, LED_OFF, LED_OFF, 8'h7F, 1'b0);
    for (int k = 4; k < 8; k++) tick(4'b0100, 8'h00, 8'h00, 8'h00, 1'b0);
    idle(2);
    chk(1, 0, 24'h1, "merge_valid");
    for (int k = 0; k < 8; k++)
      chk(0, 3'(k), (k == 2) ? 24'h010080 : 24'h0, $sformatf("merge_col%0d", k));

    // Overrun: three frames without ack, first one retained
    ack();
    idle(1);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) begin
        bit_k = 8'h01 << k;
        if (f == 0) tick(4'b1000 | 4'(k), LED_OFF, ~bit_k, LED_OFF, 1'b0);
        else        tick(4'b1000 | 4'(k), LED_OFF, LED_OFF, 8'h00, 1'b0);
      end
      idle(2);
    end
    chk(1, 0, 24'h1, "ovr_valid");
    chk(2, 0, 24'h2, "ovr_count");
    for (int k = 0; k < 8; k += 3) begin
      bit_k = 8'h01 << k;
      chk(0, 3'(k), {8'h00, bit_k, 8'h00}, $sformatf("ovr_col%0d", k));
    end

    // Ack in the completion cycle
    for (int k = 0; k < 8; k++) begin
      bit_k = 8'h80 >> k;
      tick(4'b1000 | 4'(k), ~bit_k, LED_OFF, LED_OFF, 1'b0);
    end
    ack();
    idle(1);
    chk(1, 0, 24'h1, "coll_valid");
    chk(2, 0, 24'h2, "coll_overrun");
    for (int k = 1; k < 8; k += 3) begin
      bit_k = 8'h80 >> k;
      chk(0, 3'(k), {bit_k, 8'h00, 8'h00}, $sformatf("coll_col%0d", k));
    end

    // Sync at slot 5 discards the partial frame
    ack();
    idle(1);
    for (int k = 0; k < 5; k++) tick(4'b1000 | 4'(k), 8'h00, LED_OFF, LED_OFF, 1'b0);
    tick(4'b1000, LED_OFF, 8'hFE, LED_OFF, 1'b1);
    for (int k = 1; k < 8; k++) begin
      bit_k = 8'h01 << k;
      tick(4'b1000 | 4'(k), LED_OFF, ~bit_k, LED_OFF, 1'b0);
    end
    idle(2);
    chk(3, 0, 24'h1, "sync_err1");
    chk(1, 0, 24'h1, "sync_valid");
    for (int k = 0; k < 8; k++) begin
      bit_k = 8'h01 << k;
      chk(0, 3'(k), {8'h00, bit_k, 8'h00}, $sformatf("sync_col%0d", k));
    end

    // Saturation: 300 back-to-back syncs (first is aligned, rest are errors)
    for (int i = 0; i < 300; i++) tick(4'b0000, LED_OFF, LED_OFF, LED_OFF, 1'b1);
    idle(1);
    chk(3, 0, 24'hFF, "sync_sat");
    chk(2, 0, 24'h2, "sync_sat_overrun");

    // Reset mid-frame, then a clean frame
    for (int k = 0; k < 3; k++) tick(4'b1000 | 4'(k), 8'h00, 8'h00, 8'h00, 1'b0);
    Clear_n = 1'b0;
    idle(1);
    chk(1, 0, 24'h0, "midrst_valid");
    chk(2, 0, 24'h0, "midrst_overrun");
    chk(3, 0, 24'h0, "midrst_syncerr");
    chk(0, 1, 24'h0, "midrst_rd");
    Clear_n = 1'b1;
    idle(1);
    for (int k = 0; k < 8; k++) begin
      bit_k = 8'h01 << k;
      tick(4'b1000 | 4'(k), LED_OFF, LED_OFF, ~bit_k, 1'b0);
    end
    idle(2);
    chk(1, 0, 24'h1, "post_rst_valid");
    for (int k = 0; k < 8; k += 2) begin
      bit_k = 8'h01 << k;
      chk(0, 3'(k), {8'h00, 8'h00, bit_k}, $sformatf("post_rst_col%0d", k));
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
